// File: rtl/oled_spi_burst.sv
// Burst SPI master (mode 3) for the OLED panel: {DC, data} words are queued in a
// small FIFO and shifted out back-to-back with CS held low while words keep coming.
module oled_spi_burst #(
    parameter int DIV       = 10,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_in_dc,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_cs,
    output logic             o_dc,
    output logic             o_scl,
    output logic             o_sda,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_CSOFF} state_t;

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PW:0]      r_count;
    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shift;
    logic             r_cs, r_dc, r_scl, r_sda, r_done;

    logic             w_full, w_empty, w_push, w_pop, w_term, w_last;
    logic [WIDTH:0]   w_head;
    logic [IW-1:0]    w_idx_nxt;

    function automatic logic bit_at(input logic [WIDTH-1:0] word, input logic [IW-1:0] idx);
        return LSB_FIRST ? word[idx] : word[IW'(WIDTH-1) - idx];
    endfunction

    assign w_full     = (r_count == (PW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = i_in_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_term     = (r_cnt == CW'(DIV-1));
    assign w_last     = (r_idx == IW'(WIDTH-1));
    assign w_idx_nxt  = r_idx + 1'b1;

    assign o_in_ready = !w_full;
    assign o_busy     = (r_state != S_IDLE) || !w_empty;
    assign o_cs       = r_cs;
    assign o_dc       = r_dc;
    assign o_scl      = r_scl;
    assign o_sda      = r_sda;
    assign o_done     = r_done;

    // FIFO storage needs no reset; only pointers and count define its contents.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_in_dc, i_in_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: if (w_term) w_state_nxt = S_LOW;
            S_LOW:   if (w_term) w_state_nxt = S_HIGH;
            S_HIGH: begin
                if (w_term) begin
                    if (!w_last) begin
                        w_state_nxt = S_LOW;
                    end else if (!w_empty) begin
                        // next word chains straight into LOW: no SETUP, no CS gap
                        w_pop       = 1'b1;
                        w_state_nxt = S_LOW;
                    end else begin
                        w_state_nxt = S_CSOFF;
                    end
                end
            end
            S_CSOFF: if (w_term) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_cs    <= 1'b1;
            r_dc    <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_state_nxt != r_state || r_state == S_IDLE) r_cnt <= '0;
            else                                              r_cnt <= r_cnt + 1'b1;
            if (w_pop) begin
                r_shift <= w_head[WIDTH-1:0];
                r_dc    <= w_head[WIDTH];
            end
            case (r_state)
                S_IDLE: if (w_pop) r_cs <= 1'b0;
                S_SETUP: begin
                    if (w_term) begin
                        r_scl <= 1'b0;
                        r_sda <= bit_at(r_shift, IW'(0));
                        r_idx <= '0;
                    end
                end
                S_LOW: if (w_term) r_scl <= 1'b1;
                S_HIGH: begin
                    if (w_term) begin
                        if (!w_last) begin
                            r_idx <= w_idx_nxt;
                            r_scl <= 1'b0;
                            r_sda <= bit_at(r_shift, w_idx_nxt);
                        end else begin
                            r_done <= 1'b1;
                            r_idx  <= '0;
                            if (w_pop) begin
                                r_scl <= 1'b0;
                                r_sda <= bit_at(w_head[WIDTH-1:0], IW'(0));
                            end else begin
                                r_cs <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
